// File: rtl/multi_timer.sv
// Multi-channel periodic timer: each channel counts up to (top << prescaler) and
// raises a sticky interrupt on match. One-shot mode is built only with MULTI_TIMER_ONESHOT_EN.
module multi_timer #(
  parameter int NumChannels    = 4,
  parameter int TopWidth       = 16,
  parameter int PrescalerWidth = 4,
  parameter int CounterWidth   = 32,
  localparam int ChW           = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [ChW-1:0]            cfg_ch,
  input  logic                      cfg_en,
  input  logic                      cfg_oneshot,
  input  logic [TopWidth-1:0]       cfg_top,
  input  logic [PrescalerWidth-1:0] cfg_prescaler,
  input  logic [NumChannels-1:0]    interrupt_clear,
  output logic [NumChannels-1:0]    interrupt_set,
  output logic                      irq_any,
  output logic [NumChannels-1:0]    overrun,
  output logic [NumChannels-1:0]    active,
  input  logic [ChW-1:0]            rd_ch,
  output logic [CounterWidth-1:0]   rd_count
);

  logic [CounterWidth-1:0] cnt_arr [NumChannels];
  logic [NumChannels-1:0]  irq_q;
  logic [NumChannels-1:0]  ovr_q;
  logic [NumChannels-1:0]  act_q;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    logic [TopWidth-1:0]       top_q;
    logic [PrescalerWidth-1:0] pre_q;
    logic [CounterWidth-1:0]   cnt_q;
    logic [CounterWidth-1:0]   match;
    logic                      act_r;
    logic                      irq_r;
    logic                      ovr_r;
    logic                      wr_hit;
    logic                      hit;
`ifdef MULTI_TIMER_ONESHOT_EN
    logic                      oneshot_q;
`endif

    // Out-of-range cfg_ch never equals a valid channel index, so such writes fall through.
    assign wr_hit = cfg_we && (cfg_ch == ChW'(i));
    assign match  = CounterWidth'(top_q) << pre_q;
    assign hit    = act_r && (cnt_q == match);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        top_q <= '0;
        pre_q <= '0;
`ifdef MULTI_TIMER_ONESHOT_EN
        oneshot_q <= 1'b0;
`endif
      end else if (wr_hit) begin
        top_q <= cfg_top;
        pre_q <= cfg_prescaler;
`ifdef MULTI_TIMER_ONESHOT_EN
        oneshot_q <= cfg_oneshot;
`endif
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        act_r <= 1'b0;
      end else if (wr_hit) begin
        cnt_q <= '0;
        act_r <= cfg_en;
      end else if (hit) begin
        cnt_q <= '0;
`ifdef MULTI_TIMER_ONESHOT_EN
        if (oneshot_q) act_r <= 1'b0;
`endif
      end else if (act_r) begin
        cnt_q <= cnt_q + CounterWidth'(1);
      end else begin
        cnt_q <= '0;
      end
    end

    // A match beats a same-cycle clear; a config write suppresses the match but still honours clear.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        irq_r <= 1'b0;
        ovr_r <= 1'b0;
      end else if (hit && !wr_hit) begin
        irq_r <= 1'b1;
        ovr_r <= irq_r | (ovr_r & ~interrupt_clear[i]);
      end else begin
        irq_r <= irq_r & ~interrupt_clear[i];
        ovr_r <= ovr_r & ~interrupt_clear[i];
      end
    end

    assign cnt_arr[i] = cnt_q;
    assign act_q[i]   = act_r;
    assign irq_q[i]   = irq_r;
    assign ovr_q[i]   = ovr_r;
  end

`ifndef MULTI_TIMER_ONESHOT_EN
  logic unused_cfg_oneshot;
  assign unused_cfg_oneshot = cfg_oneshot;
`endif

  assign interrupt_set = irq_q;
  assign overrun       = ovr_q;
  assign active        = act_q;
  assign irq_any       = |irq_q;

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (rd_ch == ChW'(i)) rd_count = cnt_arr[i];
    end
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter TopWidth, default 16, width of per-channel top value.
REQ-003 SHALL have parameter PrescalerWidth, default 4, width of per-channel shift prescaler.
REQ-004 SHALL have parameter CounterWidth, default 32, width of per-channel counter.
REQ-005 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have ports: cfg_we  in  1  config write strobe; cfg_ch  in  max(1,$clog2(NumChannels))  target channel.
REQ-008 SHALL have ports: cfg_en  in  1  channel enable; cfg_oneshot  in  1  1=one-shot, 0=periodic.
REQ-009 SHALL have ports: cfg_top  in  TopWidth; cfg_prescaler  in  PrescalerWidth.
REQ-010 SHALL have ports: interrupt_clear  in  NumChannels  per-channel pending clear.
REQ-011 SHALL have ports: interrupt_set  out  NumChannels  per-channel pending; irq_any  out  1  OR of interrupt_set.
REQ-012 SHALL have ports: overrun  out  NumChannels  match while pending; active  out  NumChannels  channel enabled.
REQ-013 SHALL have ports: rd_ch  in  same width as cfg_ch; rd_count  out  CounterWidth  combinational counter of rd_ch.

Function
REQ-014 SHALL compute per-channel match = zero-extended top shifted left by prescaler, truncated to CounterWidth.
REQ-015 SHALL, when a channel is active and not written this cycle, increment counter by 1 per clock if counter != match.
REQ-016 SHALL, on counter == match: counter <= 0, interrupt_set <= 1; period = match+1 clocks.
REQ-017 SHALL set overrun <= 1 on a match occurring while interrupt_set is already 1.
REQ-018 SHALL keep interrupt_set and overrun sticky until interrupt_clear for that channel; clear drops both next edge.
REQ-019 SHALL give match priority over interrupt_clear in the same cycle (interrupt_set stays 1; overrun set per REQ-017).
REQ-020 SHALL, on cfg_we with cfg_ch < NumChannels, load top, prescaler, mode, active <= cfg_en, counter <= 0 next edge.
REQ-021 SHALL give config write priority over match for the written channel (no interrupt that cycle); other channels unaffected.
REQ-022 SHALL ignore cfg_we when cfg_ch >= NumChannels.
REQ-023 SHALL, when inactive, hold counter at 0 and raise no interrupts; interrupt_set/overrun remain clearable.
REQ-024 SHALL, with match == 0 and active, raise interrupt every cycle (counter stays 0).
REQ-025 SHALL drive rd_count to 0 when rd_ch >= NumChannels.

Reset
REQ-026 SHALL, while reset == 0, asynchronously force all counters, top, prescaler, mode, active, interrupt_set, overrun to 0.
REQ-027 SHALL reset outputs: interrupt_set = 0, irq_any = 0, overrun = 0, active = 0, rd_count = 0.
REQ-028 SHALL abort any in-progress count on reset assertion mid-operation; counting resumes only after a new config write.

Configuration
REQ-029 SHALL compile one-shot mode only when macro MULTI_TIMER_ONESHOT_EN is defined.
REQ-030 SHALL, with MULTI_TIMER_ONESHOT_EN, on match of a one-shot channel also clear active (counter <= 0, stops).
REQ-031 SHALL, without MULTI_TIMER_ONESHOT_EN, ignore cfg_oneshot; all channels periodic; no mode storage.

Verification
REQ-032 SHALL cover: ch0 top=3 pre=0 en=1 periodic -> interrupt_set[0] rises 4 clocks after write edge, repeats every 4 clocks.
REQ-033 SHALL cover: ch1 top=3 pre=2 -> match=12, period 13 clocks; rd_ch=1 shows counter 0..12 then 0.
REQ-034 SHALL cover: ch0 pending, no clear across a second match -> overrun[0]=1; interrupt_clear[0] pulse -> both 0 next edge.
REQ-035 SHALL cover: interrupt_clear[2] asserted on match cycle of ch2 -> interrupt_set[2] remains 1.
REQ-036 SHALL cover: MULTI_TIMER_ONESHOT_EN, ch3 top=5 oneshot -> single interrupt after 6 clocks, active[3]=0, counter 0 thereafter.
REQ-037 SHALL cover: reset=0 mid-count with ch0 counter=2 -> all outputs 0 immediately (before next edge); no interrupt after release.
